// File: rtl/f_divsqrt_if.sv
// Handshake/data bundle between the FP issue logic and the iterative divide/sqrt unit.
// The master drives the request side and the slave returns the result.
interface f_divsqrt_if;
    logic        start;
    logic        op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        busy;
    logic        done;

    modport master (
        output start, op, data1, data2,
        input  result, flags, busy, done
    );

    modport slave (
        input  start, op, data1, data2,
        output result, flags, busy, done
    );
endinterface

// File: rtl/f_divsqrt.sv
// Iterative binary32 FDIV.S / FSQRT.S unit: radix-2 restoring recurrence, RNE rounding,
// flush-to-zero for subnormal inputs and results.
module f_divsqrt (
    input logic        clk,
    input logic        rst_n,
    f_divsqrt_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StPrep, StIter, StRnd, StFin} state_e;

    localparam logic [31:0] CanonNan = 32'h7FC0_0000;

    state_e            state_q, state_d;
    logic              op_q, op_d, sign_q, sign_d;
    logic [31:0]       a_q, a_d, b_q, b_d, result_q, result_d;
    logic [4:0]        flags_q, flags_d, cnt_q, cnt_d;
    logic signed [9:0] exp_q, exp_d;
    logic [27:0]       rem_q, rem_d;
    logic [25:0]       quo_q, quo_d;
    logic [23:0]       div_q, div_d;
    logic [51:0]       rad_q, rad_d;

    logic        s1, s2;
    logic [7:0]  e1, e2;
    logic [22:0] f1, f2;
    logic        z1, z2, inf1, inf2, nan1, nan2, snan1, snan2;
    logic [23:0] m1, m2;

    assign {s1, e1, f1} = a_q;
    assign {s2, e2, f2} = b_q;
    // A zero exponent field covers both true zeros and flushed subnormals.
    assign z1    = (e1 == 8'h00);
    assign z2    = (e2 == 8'h00);
    assign inf1  = (e1 == 8'hFF) && (f1 == 23'h0);
    assign inf2  = (e2 == 8'hFF) && (f2 == 23'h0);
    assign nan1  = (e1 == 8'hFF) && (f1 != 23'h0);
    assign nan2  = (e2 == 8'hFF) && (f2 != 23'h0);
    assign snan1 = nan1 && !f1[22];
    assign snan2 = nan2 && !f2[22];
    assign m1    = {1'b1, f1};
    assign m2    = {1'b1, f2};

    logic signed [9:0] exp_div, sq_unb, exp_sqrt;
    assign exp_div  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
    assign sq_unb   = $signed({2'b00, e1}) - 10'sd127;
    assign exp_sqrt = (sq_unb >>> 1) + 10'sd127;

    logic        spec;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;

    always_comb begin
        spec       = 1'b1;
        spec_res   = 32'h0;
        spec_flags = 5'b0;
        if (!op_q) begin
            if (nan1 || nan2) begin
                spec_res      = CanonNan;
                spec_flags[4] = snan1 || snan2;
            end else if ((z1 && z2) || (inf1 && inf2)) begin
                spec_res      = CanonNan;
                spec_flags[4] = 1'b1;
            end else if (inf1) begin
                spec_res = {s1 ^ s2, 8'hFF, 23'h0};
            end else if (z2) begin
                spec_res      = {s1 ^ s2, 8'hFF, 23'h0};
                spec_flags[3] = 1'b1;
            end else if (inf2 || z1) begin
                spec_res = {s1 ^ s2, 31'h0};
            end else begin
                spec = 1'b0;
            end
        end else begin
            if (nan1) begin
                spec_res      = CanonNan;
                spec_flags[4] = snan1;
            end else if (z1) begin
                spec_res = {s1, 31'h0};
            end else if (s1) begin
                spec_res      = CanonNan;
                spec_flags[4] = 1'b1;
            end else if (inf1) begin
                spec_res = 32'h7F80_0000;
            end else begin
                spec = 1'b0;
            end
        end
    end

    // One recurrence step; sqrt pulls two radicand bits per step against trial 4*root+1.
    logic [27:0] step_part, step_sub, step_diff, step_rem;
    logic        step_ge;

    always_comb begin
        if (op_q) begin
            step_part = {rem_q[25:0], rad_q[51:50]};
            step_sub  = {quo_q, 2'b01};
        end else begin
            step_part = rem_q;
            step_sub  = {4'b0, div_q};
        end
        step_ge   = (step_part >= step_sub);
        step_diff = step_part - step_sub;
        if (op_q) begin
            step_rem = step_ge ? step_diff : step_part;
        end else begin
            step_rem = step_ge ? {step_diff[26:0], 1'b0} : {step_part[26:0], 1'b0};
        end
    end

    logic              rnd_up, rnd_nx;
    logic [24:0]       rnd_sum;
    logic signed [9:0] rnd_exp;
    logic [22:0]       rnd_frac;
    logic [31:0]       rnd_res;
    logic [4:0]        rnd_flags;

    always_comb begin
        rnd_nx   = quo_q[1] | quo_q[0] | (rem_q != 28'h0);
        rnd_up   = quo_q[1] & (quo_q[0] | (rem_q != 28'h0) | quo_q[2]);
        rnd_sum  = {1'b0, quo_q[25:2]} + {24'h0, rnd_up};
        rnd_exp  = exp_q + (rnd_sum[24] ? 10'sd1 : 10'sd0);
        rnd_frac = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
        if (rnd_exp >= 10'sd255) begin
            rnd_res   = {sign_q, 8'hFF, 23'h0};
            rnd_flags = 5'b00101;
        end else if (rnd_exp <= 10'sd0) begin
            rnd_res   = {sign_q, 31'h0};
            rnd_flags = 5'b00011;
        end else begin
            rnd_res   = {sign_q, rnd_exp[7:0], rnd_frac};
            rnd_flags = {4'b0, rnd_nx};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rad_d    = rad_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StPrep;
                    op_d    = bus.op;
                    a_d     = bus.data1;
                    b_d     = bus.data2;
                end
            end
            StPrep: begin
                quo_d = 26'h0;
                cnt_d = 5'd0;
                div_d = m2;
                rad_d = 52'h0;
                rem_d = 28'h0;
                if (spec) begin
                    result_d = spec_res;
                    flags_d  = spec_flags;
                    state_d  = StFin;
                end else begin
                    state_d = StIter;
                    if (!op_q) begin
                        sign_d = s1 ^ s2;
                        // Pre-normalise so the first quotient bit is always 1.
                        if (m1 < m2) begin
                            rem_d = {3'b0, m1, 1'b0};
                            exp_d = exp_div - 10'sd1;
                        end else begin
                            rem_d = {4'b0, m1};
                            exp_d = exp_div;
                        end
                    end else begin
                        sign_d = 1'b0;
                        exp_d  = exp_sqrt;
                        rad_d  = sq_unb[0] ? {m1, 28'h0} : {1'b0, m1, 27'h0};
                    end
                end
            end
            StIter: begin
                quo_d = {quo_q[24:0], step_ge};
                rem_d = step_rem;
                if (op_q) rad_d = {rad_q[49:0], 2'b00};
                if (cnt_q == 5'd25) begin
                    cnt_d   = 5'd0;
                    state_d = StRnd;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StRnd: begin
                result_d = rnd_res;
                flags_d  = rnd_flags;
                state_d  = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 1'b0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            rem_q    <= 28'h0;
            quo_q    <= 26'h0;
            div_q    <= 24'h0;
            rad_q    <= 52'h0;
            cnt_q    <= 5'd0;
            result_q <= 32'h0;
            flags_q  <= 5'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            rad_q    <= rad_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.busy   = (state_q == StPrep) || (state_q == StIter) || (state_q == StRnd);
    assign bus.done   = (state_q == StFin);
endmodule

// File: tb/tb_f_divsqrt.sv
// Bench for f_divsqrt: directed vector table, handshake/reset sequences, and random
// operands checked against an exact integer-arithmetic model of binary32 div/sqrt.
module tb_f_divsqrt;
    logic clk = 1'b0;
    logic rst_n;

    f_divsqrt_if bus ();

    f_divsqrt dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        bit          special;
    } model_t;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned r;
        real rx;
        rx = x;
        r  = longint'($sqrt(rx));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // value = v * 2^sc (+ a nonzero tail below v's lsb when tail=1); RNE to 24 bits.
    function automatic logic [36:0] round_pack(input bit sg, input int sc,
                                               input longint unsigned v, input bit tail);
        int p, sh, e, be;
        longint unsigned mant, rest, half;
        bit up, nx;
        p = 63;
        while (!v[p]) p--;
        sh   = p - 23;
        mant = v >> sh;
        rest = v & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        up   = (rest > half) || ((rest == half) && (tail || mant[0]));
        nx   = (rest != 0) || tail;
        e    = p + sc;
        mant = mant + (up ? 64'd1 : 64'd0);
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e++;
        end
        be = e + 127;
        if (be >= 255) return {5'b00101, sg, 8'hFF, 23'h0};
        if (be <= 0) return {5'b00011, sg, 31'h0};
        return {4'b0, nx, sg, be[7:0], mant[22:0]};
    endfunction

    function automatic model_t ref_model(input logic op, input logic [31:0] a,
                                         input logic [31:0] b);
        model_t m;
        bit za, zb, ia, ib, na, nb, sna, snb, sg, tail;
        int ea, eb, k, sc;
        longint unsigned ma, mb, v, x;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 0);
        ib  = (eb == 255) && (b[22:0] == 0);
        na  = (ea == 255) && (a[22:0] != 0);
        nb  = (eb == 255) && (b[22:0] != 0);
        sna = na && !a[22];
        snb = nb && !b[22];
        ma  = 64'h80_0000 | 64'(a[22:0]);
        mb  = 64'h80_0000 | 64'(b[22:0]);
        m.special = 1'b1;
        m.flags   = 5'b0;
        m.res     = 32'h0;
        if (!op) begin
            sg = a[31] ^ b[31];
            if (na || nb) begin
                m.res   = 32'h7FC0_0000;
                m.flags = (sna || snb) ? 5'b10000 : 5'b00000;
            end else if ((za && zb) || (ia && ib)) begin
                m.res   = 32'h7FC0_0000;
                m.flags = 5'b10000;
            end else if (ia) begin
                m.res = {sg, 8'hFF, 23'h0};
            end else if (zb) begin
                m.res   = {sg, 8'hFF, 23'h0};
                m.flags = 5'b01000;
            end else if (ib || za) begin
                m.res = {sg, 31'h0};
            end else begin
                m.special = 1'b0;
                v    = (ma << 40) / mb;
                tail = ((ma << 40) % mb) != 0;
                sc   = ea - eb - 40;
                {m.flags, m.res} = round_pack(sg, sc, v, tail);
            end
        end else begin
            if (na) begin
                m.res   = 32'h7FC0_0000;
                m.flags = sna ? 5'b10000 : 5'b00000;
            end else if (za) begin
                m.res = {a[31], 31'h0};
            end else if (a[31]) begin
                m.res   = 32'h7FC0_0000;
                m.flags = 5'b10000;
            end else if (ia) begin
                m.res = 32'h7F80_0000;
            end else begin
                m.special = 1'b0;
                k = ea - 150;
                x = ma;
                if (k % 2 != 0) begin
                    x = x * 2;
                    k = k - 1;
                end
                x    = x << 28;
                v    = isqrt(x);
                tail = (v * v) != x;
                sc   = k / 2 - 14;
                {m.flags, m.res} = round_pack(1'b0, sc, v, tail);
            end
        end
        return m;
    endfunction

    // lat = edges after the accepting edge until DONE is seen; 100 means timed out.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [4:0] fl,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.data1 = $urandom;
        bus.data2 = $urandom;
        lat       = 0;
        busy_ok   = bus.busy;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
        if (bus.busy) busy_ok = 1'b0;
        res = bus.result;
        fl  = bus.flags;
    endtask

    task automatic do_check(input string name, input logic o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eres,
                            input logic [4:0] efl, input int elat);
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        bit          busy_ok;
        run_op(o, a, b, res, fl, lat, busy_ok);
        check({name, ".result"}, res, eres);
        check({name, ".flags"}, 32'(fl), 32'(efl));
        check({name, ".latency"}, 32'(lat), 32'(elat));
        check({name, ".busy"}, 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1;
        check({name, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 7))
                0:       return 32'h0000_0000;
                1:       return 32'h8000_0000;
                2:       return 32'h7F80_0000;
                3:       return 32'hFF80_0000;
                4:       return 32'h7FC0_0000;
                5:       return 32'h7F80_0001;
                6:       return 32'h0000_0123;
                default: return 32'h3F80_0000;
            endcase
        end
        return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    vec_t vecs [14];

    initial begin
        int          cyc, dones, done_at;
        bit          busy_ok, idle_ok, no_done;
        logic [31:0] hres, a, b;
        logic        o;
        model_t      m;

        vecs[0]  = '{"div_6_2",      1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28};
        vecs[1]  = '{"div_1_3",      1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28};
        vecs[2]  = '{"sqrt_2",       1'b1, 32'h40000000, 32'hDEADBEEF, 32'h3FB504F3, 5'h01, 28};
        vecs[3]  = '{"sqrt_neg1",    1'b1, 32'hBF800000, 32'h12345678, 32'h7FC00000, 5'h10, 1};
        vecs[4]  = '{"div_by_zero",  1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1};
        vecs[5]  = '{"div_0_0",      1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 1};
        vecs[6]  = '{"div_qnan",     1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'h00, 1};
        vecs[7]  = '{"div_overflow", 1'b0, 32'h7F000000, 32'h3E800000, 32'h7F800000, 5'h05, 28};
        vecs[8]  = '{"div_underflw", 1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 5'h03, 28};
        vecs[9]  = '{"sqrt_4",       1'b1, 32'h40800000, 32'hFFFFFFFF, 32'h40000000, 5'h00, 28};
        vecs[10] = '{"sqrt_negzero", 1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 5'h00, 1};
        vecs[11] = '{"div_snan",     1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 1};
        vecs[12] = '{"sqrt_inf",     1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 5'h00, 1};
        vecs[13] = '{"div_by_ninf",  1'b0, 32'h3F800000, 32'hFF800000, 32'h80000000, 5'h00, 1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.data1 = 32'h0;
        bus.data2 = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset.result", bus.result, 32'h0);
        check("reset.flags", 32'(bus.flags), 32'h0);
        check("reset.busy", 32'(bus.busy), 32'h0);
        check("reset.done", 32'(bus.done), 32'h0);

        foreach (vecs[i]) begin
            do_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                     vecs[i].flags, vecs[i].lat);
        end

        // START during ITER, during RND and in the DONE cycle must all be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.data1 = 32'h40C00000;
        bus.data2 = 32'h40000000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc     = 0;
        dones   = 0;
        done_at = -1;
        busy_ok = 1'b1;
        idle_ok = 1'b1;
        hres    = 32'h0;
        repeat (40) begin
            @(negedge clk);
            if (cyc == 5 || cyc == 27 || cyc == 28) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.data1 = 32'h3F800000;
                bus.data2 = 32'h40400000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) begin
                dones++;
                done_at = cyc;
                hres    = bus.result;
            end
            if (cyc < 28 && !bus.busy) busy_ok = 1'b0;
            if (cyc >= 28 && bus.busy) idle_ok = 1'b0;
        end
        bus.start = 1'b0;
        check("hs.result", hres, 32'h40400000);
        check("hs.done_count", 32'(dones), 32'd1);
        check("hs.done_at", 32'(done_at), 32'd28);
        check("hs.busy_continuous", 32'(busy_ok), 32'd1);
        check("hs.no_reaccept", 32'(idle_ok), 32'd1);

        // Asynchronous reset in the middle of ITER aborts without a DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.data1 = 32'h40C00000;
        bus.data2 = 32'h40000000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.async_busy", 32'(bus.busy), 32'h0);
        check("rst.async_result", bus.result, 32'h0);
        check("rst.async_flags", 32'(bus.flags), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        no_done = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) no_done = 1'b0;
        end
        check("rst.no_done", 32'(no_done), 32'd1);
        check("rst.result", bus.result, 32'h0);
        check("rst.flags", 32'(bus.flags), 32'h0);
        do_check("rst.after_6_2", 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);

        for (int n = 0; n < 150; n++) begin
            o = 1'($urandom);
            a = rand_operand();
            b = rand_operand();
            if (!o) a[31] = 1'($urandom);
            if (!o) b[31] = 1'($urandom);
            if (o && $urandom_range(0, 15) == 0) a[31] = 1'b1;
            m = ref_model(o, a, b);
            do_check($sformatf("rand%0d_%s_%08h_%08h", n, o ? "sqrt" : "div", a, b),
                     o, a, b, m.res, m.flags, m.special ? 1 : 28);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
